// File: rtl/matrix_loader.sv
// Serial-to-parallel matrix assembler: collects MATRIX_SIZE^2 row-major elements
// into a flat bus, holds the frame until downstream accepts, flags bad framing.
module matrix_loader #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [DATA_WIDTH-1:0]                          in_data,
  input  logic                                           in_valid,
  input  logic                                           in_last,
  output logic                                           in_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]  mat_out,
  output logic                                           mat_valid,
  input  logic                                           mat_ready,
  output logic                                           frame_err,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE+1)-1:0]   elem_count
);

  localparam int N  = MATRIX_SIZE * MATRIX_SIZE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_LOAD, S_FULL} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] elem_q [N];

  logic accept;
  logic at_end;

  assign accept = in_valid && (state_q == S_LOAD);
  assign at_end = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (at_end && in_last) begin
              state_q <= S_FULL;
              cnt_q   <= CW'(N);
            end else if (at_end || in_last) begin
              // Early or missing last: drop the partial frame and restart.
              err_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (mat_ready) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // One storage slot per element; slot k is written by the k-th beat of a frame.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        elem_q[gi] <= '0;
      end else if (accept && (cnt_q == CW'(gi))) begin
        elem_q[gi] <= in_data;
      end
    end
    assign mat_out[gi*DATA_WIDTH +: DATA_WIDTH] = elem_q[gi];
  end

  assign in_ready   = (state_q == S_LOAD);
  assign mat_valid  = (state_q == S_FULL);
  assign frame_err  = err_q;
  assign elem_count = cnt_q;

endmodule
